// File: rtl/seg7_defs.sv
// Shared constants for the three-digit seven-segment scanner.
// Segment codes are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_defs;

  localparam int unsigned N_DIGITS = 3;
  localparam int unsigned SEG_W    = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Three BCD digits in bin2bcd layout: [11:8] hundreds, [7:4] tens, [3:0] ones.
  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd3_t;

  localparam seg_t SEG_0    = 7'b1000000;
  localparam seg_t SEG_1    = 7'b1111001;
  localparam seg_t SEG_2    = 7'b0100100;
  localparam seg_t SEG_3    = 7'b0110000;
  localparam seg_t SEG_4    = 7'b0011001;
  localparam seg_t SEG_5    = 7'b0010010;
  localparam seg_t SEG_6    = 7'b0000010;
  localparam seg_t SEG_7    = 7'b1111000;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0010000;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'h7F;

  localparam logic [N_DIGITS-1:0] AN_OFF = '1;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble-to-glyph decode; 10-15 render as a dash.
module bcd_to_7seg
  import seg7_defs::*;
(
  input  logic [3:0]       nib,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed three-digit display driver with frame-aligned value commit
// and leading-zero blanking.
module seg7_scan
  import seg7_defs::*;
#(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [11:0]         bcd,
  input  logic                bcd_valid,
  input  logic                blank,
  output logic [SEG_W-1:0]    seg_n,
  output logic [N_DIGITS-1:0] an_n,
  output logic                update_pending
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0]    cnt;
  logic [1:0]       idx;
  bcd3_t            pend;
  bcd3_t            disp;
  logic             tick;
  logic             commit;
  logic [3:0]       nib;
  logic             dig_blank;
  logic [SEG_W-1:0] dec_seg;

  assign tick   = (cnt == CW'(CLK_DIV - 1));
  assign commit = tick && (idx == 2'd2);

  // Select the active digit and decide whether leading-zero blanking hides it.
  always_comb begin
    nib       = disp.ones;
    dig_blank = blank;
    case (idx)
      2'd1: begin
        nib       = disp.tens;
        dig_blank = blank || ((disp.hund == 4'd0) && (disp.tens == 4'd0));
      end
      2'd2: begin
        nib       = disp.hund;
        dig_blank = blank || (disp.hund == 4'd0);
      end
      default: begin
        nib       = disp.ones;
        dig_blank = blank;
      end
    endcase
  end

  bcd_to_7seg u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= 2'd0;
      pend           <= '0;
      disp           <= '0;
      update_pending <= 1'b0;
      seg_n          <= SEG_OFF;
      an_n           <= AN_OFF;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;

      if (bcd_valid) pend <= bcd3_t'(bcd);

      // A strobe coinciding with the frame wrap bypasses the pending stage.
      if (commit) begin
        disp           <= bcd_valid ? bcd3_t'(bcd) : pend;
        update_pending <= 1'b0;
      end else if (bcd_valid) begin
        update_pending <= 1'b1;
      end

      if (dig_blank) begin
        seg_n <= SEG_OFF;
        an_n  <= AN_OFF;
      end else begin
        seg_n <= dec_seg;
        an_n  <= ~(N_DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan at CLK_DIV=4: a directed vector table, corner-case
// sequences and random traffic, all checked against a cycle-count reference model.
module tb_seg7_scan;

  localparam int unsigned DIV = 4;
  localparam int unsigned FRAME = 3 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        blank;
  logic [6:0]  seg_n;
  logic [2:0]  an_n;
  logic        update_pending;

  seg7_scan #(.CLK_DIV(DIV)) dut (
    .clk            (clk),
    .rst            (rst),
    .bcd            (bcd),
    .bcd_valid      (bcd_valid),
    .blank          (blank),
    .seg_n          (seg_n),
    .an_n           (an_n),
    .update_pending (update_pending)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference state: edges since reset release, committed and captured values.
  int          k;
  logic [11:0] m_disp;
  logic [11:0] m_pend;
  logic        m_up;
  logic [6:0]  e_seg;
  logic [2:0]  e_an;
  logic [6:0]  glyph [0:15];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, exp);
  endtask

  // Expected display for a digit position given the shown value and blank input.
  task automatic predict(input int pos, input logic [11:0] v, input logic bl);
    int h, t, o, n;
    logic off;
    h = int'(v[11:8]); t = int'(v[7:4]); o = int'(v[3:0]);
    n = (pos == 0) ? o : (pos == 1) ? t : h;
    off = bl || (pos == 2 && h == 0) || (pos == 1 && h == 0 && t == 0);
    if (off) begin
      e_seg = 7'h7F; e_an = 3'b111;
    end else begin
      e_seg = glyph[n];
      e_an  = 3'b111;
      e_an[pos] = 1'b0;
    end
  endtask

  // Apply one cycle of inputs, advance the model, and check all outputs.
  task automatic cycle(input logic r, input logic v, input logic [11:0] b, input logic bl);
    logic cm;
    rst = r; bcd_valid = v; bcd = b; blank = bl;
    @(posedge clk);
    if (r) begin
      k = 0; m_disp = '0; m_pend = '0; m_up = 1'b0;
      e_seg = 7'h7F; e_an = 3'b111;
    end else begin
      k++;
      predict(((k - 1) / DIV) % 3, m_disp, bl);
      cm = (k % FRAME) == 0;
      if (cm) begin
        m_disp = v ? b : m_pend;
        m_up   = 1'b0;
      end else if (v) begin
        m_up = 1'b1;
      end
      if (v) m_pend = b;
    end
    #1;
    chk("seg_n", int'(seg_n), int'(e_seg));
    chk("an_n", int'(an_n), int'(e_an));
    chk("update_pending", int'(update_pending), int'(m_up));
  endtask

  task automatic idle(input int n, input logic bl);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 12'h000, bl);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
  endtask

  typedef struct {
    logic        v;
    logic [11:0] b;
    logic        bl;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        up;
  } vec_t;

  vec_t tbl [0:14];

  initial begin
    glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
    glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
    glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
    glyph[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) glyph[i] = 7'b0111111;

    // Reset release with no strobe, then a 12'h255 strobe and its commit frame.
    for (int i = 0; i < 4; i++)  tbl[i] = '{1'b0, 12'h000, 1'b0, 7'b1000000, 3'b110, 1'b0};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 7'h7F, 3'b111, 1'b0};
    tbl[5]  = '{1'b1, 12'h255, 1'b0, 7'h7F, 3'b111, 1'b1};
    tbl[6]  = '{1'b0, 12'h000, 1'b0, 7'h7F, 3'b111, 1'b1};
    for (int i = 7; i < 11; i++) tbl[i] = '{1'b0, 12'h000, 1'b0, 7'h7F, 3'b111, 1'b1};
    tbl[11] = '{1'b0, 12'h000, 1'b0, 7'h7F, 3'b111, 1'b0};
    tbl[12] = '{1'b0, 12'h000, 1'b0, 7'b0010010, 3'b110, 1'b0};
    tbl[13] = '{1'b0, 12'h000, 1'b0, 7'b0010010, 3'b110, 1'b0};
    tbl[14] = '{1'b0, 12'h000, 1'b0, 7'b0010010, 3'b110, 1'b0};

    k = 0; m_disp = '0; m_pend = '0; m_up = 1'b0;
    do_reset();
    chk("reset_seg", int'(seg_n), 'h7F);
    chk("reset_an", int'(an_n), 'b111);
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, tbl[i].v, tbl[i].b, tbl[i].bl);
      chk($sformatf("tbl%0d_seg", i), int'(seg_n), int'(tbl[i].seg));
      chk($sformatf("tbl%0d_an", i), int'(an_n), int'(tbl[i].an));
      chk($sformatf("tbl%0d_up", i), int'(update_pending), int'(tbl[i].up));
    end
    // Rest of the 255 frame: tens 5, hundreds 2.
    idle(FRAME, 1'b0);

    // Two strobes in one frame: only the last is committed.
    do_reset();
    idle(2, 1'b0);
    cycle(1'b0, 1'b1, 12'h100, 1'b0);
    idle(2, 1'b0);
    cycle(1'b0, 1'b1, 12'h042, 1'b0);
    idle(2 * FRAME, 1'b0);
    chk("last_wins_disp", int'(m_disp), 'h042);

    // Strobe exactly on the commit edge: pending flag never rises.
    do_reset();
    idle(FRAME - 1, 1'b0);
    cycle(1'b0, 1'b1, 12'h007, 1'b0);
    chk("direct_commit_up", int'(update_pending), 0);
    idle(FRAME, 1'b0);

    // Dash digits with an unblanked zero in the tens slot.
    do_reset();
    cycle(1'b0, 1'b1, 12'hA0F, 1'b0);
    idle(2 * FRAME, 1'b0);

    // Blank asserted mid-frame, then released; scanning continues in place.
    idle(5, 1'b0);
    idle(3, 1'b1);
    idle(FRAME, 1'b0);

    // Reset while a value is pending discards it.
    do_reset();
    idle(2, 1'b0);
    cycle(1'b0, 1'b1, 12'h987, 1'b0);
    idle(3, 1'b0);
    do_reset();
    idle(FRAME + 2, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, v, bl;
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 9) == 0);
      bl = ($urandom_range(0, 15) == 0);
      cycle(r, v, 12'($urandom), bl);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, meaning clk cycles per digit slot (minimum 2).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port bcd, input, 12, three BCD digits: [11:8] hundreds, [7:4] tens, [3:0] ones (bin2bcd output format).
REQ-005 SHALL have port bcd_valid, input, 1, one-cycle strobe that captures bcd.
REQ-006 SHALL have port blank, input, 1, level; 1 turns all digits off.
REQ-007 SHALL have port seg_n, output, 7, segments {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port an_n, output, 3, digit anodes, active-low; an_n[0] = ones, an_n[2] = hundreds.
REQ-009 SHALL have port update_pending, output, 1, high while a captured value awaits frame commit.

Function
REQ-010 Prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL assert for one cycle when count = CLK_DIV-1.
REQ-011 Digit index SHALL advance 0->1->2->0 on each tick; index 3 SHALL be unreachable.
REQ-012 bcd_valid=1 SHALL load bcd into the pending register and set update_pending; with several strobes before commit, the last one wins.
REQ-013 Commit SHALL occur on the tick that wraps index 2->0: display register <= pending, update_pending cleared.
REQ-014 bcd_valid in the same cycle as a commit tick SHALL commit the new bcd directly and leave update_pending=0.
REQ-015 The display register SHALL change only at commit; no tearing within a frame.
REQ-016 seg_n/an_n SHALL be registered: 1-cycle latency from index/display change.
REQ-017 Active digit SHALL drive exactly one an_n bit low; the others SHALL stay high.
REQ-018 Decode SHALL map 0-9 to standard glyphs; 0 = 7'b1000000 and 8 = 7'b0000000 (active-low, g MSB).
REQ-019 A nibble value of 10-15 SHALL display a dash, seg_n = 7'b0111111.
REQ-020 Leading-zero blanking: hundreds SHALL be blanked if 0; tens SHALL be blanked if hundreds=0 and tens=0; ones SHALL never be blanked.
REQ-021 A blanked digit SHALL drive an_n bit high and seg_n = 7'h7F.
REQ-022 blank=1 SHALL force an_n=3'b111 and seg_n=7'h7F on the next cycle; prescaler, index, capture and commit SHALL continue running.

Reset
REQ-023 rst SHALL clear prescaler, index, pending register, display register and update_pending to 0.
REQ-024 During rst, seg_n SHALL be 7'h7F and an_n SHALL be 3'b111; the first cycle after release SHALL show ones digit "0".
REQ-025 rst asserted mid-frame or with update_pending=1 SHALL discard the pending value.

Structure
REQ-026 Segment glyph constants, the dash and off codes, and the digit count (3) SHALL live in shared header seg7_defs.
REQ-027 The nibble-to-segment decode SHALL be sub-module bcd_to_7seg (4-bit in, 7-bit active-low out, combinational).
REQ-028 The top SHALL hold only prescaler, index, pending/display registers and output registers.

Verification (CLK_DIV=4)
REQ-029 Reset release, no strobe -> an_n cycles 110 for 4 cycles then 111 (tens and hundreds blanked); seg_n=7'b1000000 while an_n=110.
REQ-030 bcd=12'h255 strobe -> update_pending=1 until next 2->0 wrap; the following frame shows 5,5,2 on an_n 110,101,011.
REQ-031 Strobes 12'h100 then 12'h042 within one frame -> only 042 is committed; hundreds blanked, tens "4", ones "2".
REQ-032 bcd_valid with 12'h007 exactly on the commit tick -> 007 displayed in that frame with update_pending never high; only ones shown.
REQ-033 bcd=12'hA0F -> hundreds and ones show dash 7'b0111111, tens "0" (not blanked because hundreds is nonzero).
REQ-034 blank=1 mid-frame -> an_n=111 one cycle later; on deassert, scanning resumes at the current index without restart; rst with update_pending=1 -> "0" shown after release.
